// File: rtl/vxv_chunk_sequencer.sv
// ============================================================================
// Module   : vxv_chunk_sequencer
// Purpose  : Captures a vector into an external vector memory and streams the
//            zero-padded memory contents back out as fixed-size chunks of
//            no_of_units elements, most significant chunk first, under a
//            valid/ready handshake.
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            load_valid/load_ready - load handshake, load_data is the vector
//            mem_write_enable/data - one-cycle write strobe to vector memory
//            mem_read_data         - padded vector memory contents
//            start/start_error     - begin a pass / pass refused (no vector)
//            busy, done            - activity flag, end-of-pass pulse
//            chunk_valid/ready     - chunk handshake
//            chunk_data/index/last - current chunk, its number, final flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vxv_chunk_sequencer #(
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int no_of_units                     = 8,
    parameter int additional                      = no_of_units - (number_of_equations_per_cluster % no_of_units),
    parameter int total                           = number_of_equations_per_cluster + additional,
    parameter int number_of_chunks                = total / no_of_units,
    // Must be wide enough to hold number_of_chunks-1.
    parameter int chunk_index_width               = 8
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 load_valid,
    output logic                                                 load_ready,
    input  logic [element_width*number_of_equations_per_cluster-1:0] load_data,
    output logic                                                 mem_write_enable,
    output logic [element_width*number_of_equations_per_cluster-1:0] mem_write_data,
    input  logic [element_width*total-1:0]                       mem_read_data,
    input  logic                                                 start,
    output logic                                                 start_error,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 chunk_valid,
    input  logic                                                 chunk_ready,
    output logic [element_width*no_of_units-1:0]                 chunk_data,
    output logic [chunk_index_width-1:0]                         chunk_index,
    output logic                                                 chunk_last
);

    localparam int c_chunk_w = element_width * no_of_units;
    localparam int c_mem_w   = element_width * total;
    localparam logic [chunk_index_width-1:0] c_last_index =
        chunk_index_width'(number_of_chunks - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_STREAM = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                                                 r_state;
    state_t                                                 w_state_next;
    logic                                                   r_vector_loaded;
    logic                                                   w_set_loaded;
    logic                                                   r_start_error;
    logic                                                   w_start_error_next;
    logic                                                   w_capture;
    logic [chunk_index_width-1:0]                           r_chunk_index;
    logic [chunk_index_width-1:0]                           w_index_next;
    logic [element_width*number_of_equations_per_cluster-1:0] r_mem_write_data;
    logic [c_chunk_w-1:0]                                   w_chunks [number_of_chunks];
    logic [c_chunk_w-1:0]                                   w_chunk_data;
    logic                                                   w_is_last;

    // Slice the padded memory image into chunks; chunk 0 holds the MSBs so
    // element 1 of the vector leads the stream and the zero pad trails it.
    generate
        for (genvar k = 0; k < number_of_chunks; k++) begin : g_chunk_slice
            assign w_chunks[k] = mem_read_data[c_mem_w-1-k*c_chunk_w -: c_chunk_w];
        end
    endgenerate

    always_comb begin
        w_chunk_data = '0;
        for (int k = 0; k < number_of_chunks; k++) begin
            if (r_chunk_index == chunk_index_width'(k)) begin
                w_chunk_data = w_chunks[k];
            end
        end
    end

    assign w_is_last = (r_chunk_index == c_last_index);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_capture          = 1'b0;
        w_set_loaded       = 1'b0;
        w_start_error_next = 1'b0;
        w_index_next       = r_chunk_index;

        case (r_state)
            S_IDLE: begin
                // A load wins over a simultaneous start; the start is
                // silently dropped rather than reported.
                if (load_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_WRITE;
                end else if (start) begin
                    if (r_vector_loaded) begin
                        w_index_next = '0;
                        w_state_next = S_STREAM;
                    end else begin
                        w_start_error_next = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_set_loaded = 1'b1;
                w_state_next = S_IDLE;
            end
            S_STREAM: begin
                if (chunk_ready) begin
                    if (w_is_last) begin
                        w_index_next = '0;
                        w_state_next = S_FINISH;
                    end else begin
                        w_index_next = r_chunk_index + chunk_index_width'(1);
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_vector_loaded  <= 1'b0;
            r_start_error    <= 1'b0;
            r_chunk_index    <= '0;
            r_mem_write_data <= '0;
        end else begin
            r_state       <= w_state_next;
            r_start_error <= w_start_error_next;
            r_chunk_index <= w_index_next;
            if (w_capture) begin
                r_mem_write_data <= load_data;
            end
            // The flag survives completed passes so a repeated start replays
            // the stored vector; only reset clears it.
            if (w_set_loaded) begin
                r_vector_loaded <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (state-decoded, so the strobes are mutually exclusive and
    // drop immediately with an asynchronous reset)
    // ------------------------------------------------------------------
    assign load_ready       = (r_state == S_IDLE) && !reset;
    assign mem_write_enable = (r_state == S_WRITE);
    assign mem_write_data   = r_mem_write_data;
    assign start_error      = r_start_error;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_FINISH);
    assign chunk_valid      = (r_state == S_STREAM);
    assign chunk_data       = w_chunk_data;
    assign chunk_index      = r_chunk_index;
    assign chunk_last       = (r_state == S_STREAM) && w_is_last;

endmodule

`default_nettype wire

// File: doc/vxv_chunk_sequencer.md
VXV_CHUNK_SEQUENCER -- requirements
Module: vxv_chunk_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- number_of_equations_per_cluster, 9, vector length N.
- element_width, 32, bits per element W.
- no_of_units, 8, parallel multiply units U.
- additional, U-(N%U), zero-pad elements.
- total, N+additional, padded length.
- number_of_chunks, total/U, chunks per pass.
- chunk_index_width, 8, counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, all state on rising edge.
- reset, in, 1, asynchronous, active-high.
- load_valid, in, 1, load request.
- load_ready, out, 1, sequencer accepts load.
- load_data, in, W*N, new vector.
- mem_write_enable, out, 1, vector-memory write strobe.
- mem_write_data, out, W*N, vector-memory write data.
- mem_read_data, in, W*total, vector-memory contents (data in MSBs, zero pad in LSBs).
- start, in, 1, begin streaming pass.
- start_error, out, 1, one-cycle pulse: start with no vector loaded.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse: pass complete.
- chunk_valid, out, 1, chunk_data valid.
- chunk_ready, in, 1, consumer accepts chunk.
- chunk_data, out, W*U, current chunk.
- chunk_index, out, chunk_index_width, current chunk number.
- chunk_last, out, 1, current chunk is final.

Function
REQ-003 States: IDLE, WRITE, STREAM, FINISH; encoding free.
REQ-004 IDLE: load_ready=1; load_valid=1 captures load_data into mem_write_data; next state WRITE.
REQ-005 WRITE: mem_write_enable=1 for exactly one cycle; vector_loaded flag set; return to IDLE. Load-to-memory-update latency is 2 clk edges.
REQ-006 IDLE with start=1 and no load_valid: if vector_loaded=1, go to STREAM with chunk_index=0; otherwise stay in IDLE and pulse start_error next cycle.
REQ-007 IDLE with load_valid=1 and start=1 together: load has priority; start is dropped with no error.
REQ-008 In every state except IDLE: load_ready=0; load_valid and start are ignored.
REQ-009 STREAM: chunk_valid=1.
- chunk k = mem_read_data[W*total-1-k*W*U -: W*U] (MSB-first).
- chunk_last=1 when k=number_of_chunks-1.
REQ-010 STREAM with chunk_valid=1 and chunk_ready=0: chunk_data, chunk_index and chunk_last held stable.
REQ-011 STREAM with chunk_ready=1: if not last, chunk_index increments next cycle; if last, next state FINISH. Throughput is one chunk per cycle with chunk_ready held high.
REQ-012 FINISH: done=1 for one cycle; chunk_valid=0; next state IDLE. vector_loaded is retained, so a repeated start replays the same vector.
REQ-013 When N%U=0, additional=U; the final chunk is all zeros and is still streamed.
REQ-014 chunk_index_width SHALL hold number_of_chunks-1.
REQ-015 chunk_valid, mem_write_enable, done and start_error SHALL never be high in the same cycle.

Reset
REQ-016 reset=1 forces, asynchronously:
- state to IDLE.
- vector_loaded, chunk_index and mem_write_data to 0.
- all strobe and valid outputs to 0.
- load_ready to 1 once reset is released.
REQ-017 Reset asserted during WRITE or STREAM aborts the operation: no done pulse; next start raises start_error until a new load completes.

Verification
REQ-018 Bench SHALL cover, with N=9, W=32, U=8 (total=16, 2 chunks):
- Load elements 1..9 -> one mem_write_enable pulse 1 cycle after accept. start -> chunk0 = elements 1..8, chunk1 = {element 9, 7 zeros}, chunk_last on chunk1, done 1 cycle after chunk1 accepted.
- start after reset, no load -> start_error one-cycle pulse, busy stays 0, chunk_valid stays 0.
- chunk_ready low 3 cycles on chunk0 -> chunk_data and chunk_index=0 stable throughout. Total pass 5 cycles STREAM + 1 FINISH.
- load_valid and start in the same IDLE cycle -> write occurs, no STREAM entry, no start_error.
- reset mid-STREAM at chunk_index=1 -> outputs cleared immediately, no done. Subsequent start -> start_error.
- N=8 -> 2 chunks, second chunk all zeros, done after 2 accepts. Repeated start without reload -> identical chunks.
